// File: rtl/icg_enable_ctrl_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
// State encoding is exported on STATE for debug, so values are fixed.
package icg_enable_ctrl_pkg;

    localparam int STATE_W         = 2;
    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_WAKE_CYCLES = 2;
    localparam int DEF_CNT_W       = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN    = 2'd0,
        ST_GATED  = 2'd1,
        ST_WAKING = 2'd2
    } state_e;

    // The gated clock runs in every state except GATED (including the illegal code).
    function automatic logic gate_open(input state_e s);
        return (s != ST_GATED);
    endfunction

endpackage

// File: rtl/icg_enable_cnt.sv
// Saturating phase counter shared by the idle and wake phases of the controller.
// term flags the cycle whose increment would reach limit; counter holds while hold=1.
module icg_enable_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             term
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!hold) begin
            if (clr) begin
                cnt <= '0;
            end else if (inc && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Compare one bit wider so cnt+1 cannot wrap before the compare.
    assign term = (({1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, limit});

endmodule

// File: rtl/icg_enable_ctrl.sv
// Drives E/TE of a negative-polarity ICG: idle-count or sleep-handshake gating, timed wake.
// E/READY/SLEEP_ACK/STATE are registered off CLK; TE is a direct passthrough of SE.
module icg_enable_ctrl
    import icg_enable_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               BUSY,
    input  logic               AUTO_EN,
    input  logic               SLEEP_REQ,
    output logic               SLEEP_ACK,
    input  logic               WAKE_REQ,
    input  logic               SE,
    output logic               E,
    output logic               TE,
    output logic               READY,
    output logic [STATE_W-1:0] STATE
);

    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_LIM = CNT_W'(WAKE_CYCLES);

    state_e           state;
    state_e           nxt;
    logic             idle;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_term;
    logic [CNT_W-1:0] cnt_lim;

    assign idle = !BUSY && (AUTO_EN || SLEEP_REQ);

    icg_enable_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (CLK),
        .rst   (RST),
        .hold  (SE),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (cnt_lim),
        .term  (cnt_term)
    );

    always_comb begin
        nxt     = state;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        cnt_lim = IDLE_LIM;
        case (state)
            ST_RUN: begin
                // A wake request on the terminal idle cycle wins over gating.
                if (WAKE_REQ || !idle) begin
                    cnt_clr = 1'b1;
                end else if (cnt_term) begin
                    nxt     = ST_GATED;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_GATED: begin
                cnt_clr = 1'b1;
                if (WAKE_REQ || (!SLEEP_REQ && !AUTO_EN)) begin
                    nxt = ST_WAKING;
                end
            end
            ST_WAKING: begin
                cnt_lim = WAKE_LIM;
                if (cnt_term) begin
                    nxt     = ST_RUN;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                nxt     = ST_RUN;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the transition edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_RUN;
            E         <= 1'b1;
            READY     <= 1'b1;
            SLEEP_ACK <= 1'b0;
        end else if (!SE) begin
            state     <= nxt;
            E         <= gate_open(nxt);
            READY     <= (nxt == ST_RUN);
            SLEEP_ACK <= (nxt == ST_GATED) && SLEEP_REQ;
        end
    end

    assign TE    = SE;
    assign STATE = state;

endmodule
